// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the data RAM load/store unit.
// Byte lanes are little-endian: offset 0 selects bits [7:0].
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

    localparam int unsigned LANE_BYTES = 4;

    // The reserved encoding behaves as a full word everywhere downstream.
    function automatic size_e norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SZ_W : size_e'(raw);
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return off;
            SZ_H:    return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input size_e sz, input logic [1:0] off);
        logic [31:0] m;
        case (sz)
            SZ_B:    m = 32'h0000_00FF;
            SZ_H:    m = 32'h0000_FFFF;
            default: m = '1;
        endcase
        return m << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input size_e sz, input logic sgn);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (sz)
            SZ_B:    return {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extract/extend a loaded sub-word and merge
// store data into the previously read word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] mask;
    logic [31:0] wshift;

    always_comb begin
        mask       = lane_mask(size, off);
        wshift     = wdata << {off, 3'b000};
        load_data  = lane_extract(rd_word, off, size, sgn);
        merge_data = (old_word & ~mask) | (wshift & mask);
    end

endmodule

// File: rtl/data_ram_lsu.sv
// Load/store initiator for the byte-enable-less data RAM; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them down.
module data_ram_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_spo
);

    state_e                state, state_nx;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [1:0]            off_q;
    size_e                 size_q;
    logic                  sgn_q, we_q, err_q;
    logic [DATA_WIDTH-1:0] wdata_q, old_q, rdata_q;
    logic [DATA_WIDTH-1:0] load_data, merge_data;

    logic  accept, req_err;
    size_e size_in;
    logic  unused_addr_hi;

    assign size_in        = norm_size(req_size);
    assign accept         = req_valid & req_ready;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = misaligned(size_in, req_addr[1:0]);
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)                        state_nx = RESP;
                else if (req_we && size_in == SZ_W) state_nx = WR;
                else                                state_nx = RD;
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Offset is aligned at accept time; for trapped requests it is never used.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wa_q    <= '0;
            off_q   <= '0;
            size_q  <= SZ_B;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            wa_q    <= req_addr[ADDR_WIDTH+1:2];
            off_q   <= align_off(size_in, req_addr[1:0]);
            size_q  <= size_in;
            sgn_q   <= req_signed;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
        end else if (state == RD) begin
            if (we_q) old_q   <= ram_spo;
            else      rdata_q <= load_data;
        end
    end

    lsu_byte_lane u_lane (
        .rd_word    (ram_spo),
        .old_word   (old_q),
        .wdata      (wdata_q),
        .off        (off_q),
        .size       (size_q),
        .sgn        (sgn_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        ram_a     = wa_q;
        ram_we    = (state == WR);
        ram_d     = '0;
        if (state == WR) ram_d = (size_q == SZ_W) ? wdata_q : merge_data;
    end

endmodule

// File: tb/tb_data_ram_lsu.sv
// Scoreboard bench for data_ram_lsu with a behavioural RAM; expected results come from a byte-level model.
module tb_data_ram_lsu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [14:0] ram_a;
    logic [31:0] ram_d, ram_spo;
    logic        ram_we;

    logic [31:0] mem [0:32767];

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        int          weoff;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, we_cnt = 0, we_start = 0, last_we_cyc = 0, hs_cyc = 0;

    data_ram_lsu #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_spo = mem[ram_a];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

    always @(negedge clk) if (ram_we) begin
        we_cnt      = we_cnt + 1;
        last_we_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, waits for acceptance and pushes the model's prediction.
    task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          nb, off, wa;
        logic [31:0] w, v;
        bit          ok;
        req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("req_accept", {31'b0, ok}, 32'd1);
        acc_cyc  = cyc;
        we_start = we_cnt;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        wa  = int'(addr[16:2]);
        w   = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
        e.rdata = 32'h0; e.err = 1'b0; e.lat = 2; e.wes = 0; e.weoff = 0;
        if (TRAP && (off % nb) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            off = off - (off % nb);
            if (we) begin
                for (int i = 0; i < nb; i++) w[(off+i)*8 +: 8] = wd[i*8 +: 8];
                ref_mem[wa] = w;
                e.lat   = (nb == 4) ? 2 : 3;
                e.wes   = 1;
                e.weoff = e.lat - 1;
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[i*8 +: 8] = w[(off+i)*8 +: 8];
                if (sg && v[nb*8-1])
                    for (int i = nb; i < 4; i++) v[i*8 +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic compare_rsp(input exp_t e);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("latency", cyc - acc_cyc, e.lat);
        check("we_count", we_cnt - we_start, e.wes);
        if (e.wes != 0) check("we_cycle", last_we_cyc - acc_cyc, e.weoff);
    endtask

    // Waits for the response with rsp_ready high and consumes it.
    task automatic collect();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check("rsp_seen", {31'b0, seen}, 32'd1);
        if (seen && sb.size() > 0) compare_rsp(sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
        send(we, sz, sg, addr, wd);
        collect();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] saved;
        bit          seen;

        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_ram_a", {17'b0, ram_a}, 32'd0);
        check("rst_ram_d", ram_d, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        xfer(1, 2'd2, 0, 32'h1000, 32'hDEADBEEF);
        xfer(0, 2'd2, 0, 32'h1000, 32'h0);
        xfer(1, 2'd0, 0, 32'h1001, 32'h00000055);
        xfer(0, 2'd2, 0, 32'h1000, 32'h0);

        xfer(1, 2'd2, 0, 32'h2000, 32'h8000F0FF);
        xfer(0, 2'd0, 1, 32'h2000, 32'h0);
        xfer(0, 2'd0, 0, 32'h2001, 32'h0);
        xfer(0, 2'd1, 1, 32'h2002, 32'h0);
        xfer(0, 2'd1, 0, 32'h2002, 32'h0);
        xfer(0, 2'd0, 1, 32'h2003, 32'h0);

        // Response stall with a second request waiting behind it.
        send(0, 2'd2, 0, 32'h1000, 32'h0);
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check("stall_rsp_seen", {31'b0, seen}, 32'd1);
        e = sb.pop_front();
        compare_rsp(e);
        #1;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b1; req_addr = 32'h2000;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, e.rdata);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        hs_cyc = cyc;
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        send(0, 2'd0, 1, 32'h2000, 32'h0);
        check("accept_after_hs", acc_cyc, hs_cyc + 1);
        collect();

        xfer(1, 2'd1, 0, 32'h2002, 32'hABCD1234);
        xfer(0, 2'd2, 0, 32'h2000, 32'h0);
        xfer(0, 2'd1, 1, 32'h2003, 32'h0);

        xfer(1, 2'd2, 0, 32'h3000, 32'h11111111);
        xfer(1, 2'd2, 0, 32'h3002, 32'hAABBCCDD);
        xfer(0, 2'd2, 0, 32'h3000, 32'h0);

        xfer(1, 2'd3, 0, 32'h6000, 32'hCAFEF00D);
        xfer(0, 2'd3, 0, 32'h6000, 32'h0);
        xfer(0, 2'd2, 0, 32'h80021000, 32'h0);

        // Reset asserted while a byte store is in its write cycle.
        xfer(1, 2'd2, 0, 32'h5000, 32'h12345678);
        saved = ref_mem[32'h5000 >> 2];
        send(1, 2'd0, 0, 32'h5001, 32'h00000077);
        ref_mem[32'h5000 >> 2] = saved;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_we) begin seen = 1'b1; break; end
        end
        check("midrst_wr_seen", {31'b0, seen}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_ram_we", {31'b0, ram_we}, 32'd0);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_ram_a", {17'b0, ram_a}, 32'd0);
        check("midrst_ram_d", ram_d, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        sb.delete(sb.size() - 1);
        @(posedge clk);
        #3 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        xfer(0, 2'd2, 0, 32'h5000, 32'h0);

        for (int i = 0; i < 16; i++) xfer(1, 2'd2, 0, 32'h4000 + 32'(i * 4), $urandom);
        for (int i = 0; i < 40; i++)
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 32'h4000 + 32'($urandom_range(0, 63)), $urandom);
        for (int i = 0; i < 16; i++) xfer(0, 2'd2, 0, 32'h4000 + 32'(i * 4), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
